imem_loader: RTL and testbench

- Writable instruction memory with a byte-stream load port. It is the writer-side counterpart of the CPU's read-only instruction fetch.
- A host streams program bytes in big-endian order over a valid/ready handshake. The block stores them and holds the CPU in stall until the load completes.
- After the load, the CPU fetches 32-bit words combinationally, exactly as from the existing instruction memory.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_byte_ram.sv | 48 ++++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the loadable instruction
//                memory: loader state encoding, default capacity and the
//                instruction word size in bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Loader state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_MEM_BYTES = 64;
  localparam int WORD_BYTES        = 4;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_ram
//  Description : Byte-wide storage with one synchronous write port and four
//                combinational read lanes forming a big-endian 32-bit word.
//                Lane k reads (raddr_i + k) mod MEM_BYTES, so a word read
//                near the top of memory wraps to byte 0.
//  Ports       : clock    - write clock
//                we_i     - write enable
//                waddr_i  - byte write index
//                wdata_i  - byte write data
//                raddr_i  - byte read index of the word's MSB
//                rdata_o  - {m[a], m[a+1], m[a+2], m[a+3]}
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_byte_ram
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  // Contents are deliberately not reset: a reset during a load keeps
  // whatever bytes were already written.
  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // ADDR_W-bit addition wraps naturally because MEM_BYTES is a power of two.
  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
    logic [ADDR_W-1:0] lane_idx;
    assign lane_idx                = raddr_i + ADDR_W'(k);
    assign rdata_o[31-8*k -: 8]    = mem_q[lane_idx];
  end

endmodule : imem_byte_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Writable instruction memory loaded by a host over a
//                byte-stream valid/ready handshake (big-endian). The CPU is
//                held in stall until the programmed number of bytes has been
//                received; afterwards it fetches 32-bit words
//                combinationally.
//  Ports       : clock, reset        - clock, synchronous active-high reset
//                start, length       - begin a load of 'length' bytes
//                in_valid, in_byte   - host byte stream
//                in_ready            - byte accepted this cycle
//                fetch_addr          - CPU byte address
//                fetch_data          - big-endian word at fetch_addr
//                fetch_misaligned    - fetch_addr[1:0] != 0
//                cpu_hold            - stall request to the PC
//                done                - load complete
//                error               - last start had an illegal length
//                byte_count          - bytes accepted in current/last load
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] length,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  output logic            in_ready,
  input  logic [31:0]     fetch_addr,
  output logic [31:0]     fetch_data,
  output logic            fetch_misaligned,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] byte_count
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] len_q,   len_d;
  logic            error_q, error_d;

  logic            legal_len;
  logic            xfer;
  logic [ADDR_W:0] count_inc;
  logic            w_unused_addr;

  // Nonzero, whole words, and fits in memory
  assign legal_len = (length != '0) && (length[1:0] == 2'b00) && (length <= MAX_LEN);
  assign xfer      = in_valid && (state_q == LOAD);
  assign count_inc = count_q + ONE;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      error_q <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    error_d = error_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (legal_len) begin
            state_d = LOAD;
            len_d   = length;
            count_d = '0;
            error_d = 1'b0;
          end else begin
            // Illegal request: flag it, keep everything else as is
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  assign in_ready   = (state_q == LOAD);
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign byte_count = count_q;

  // ---------------------------------------------------------------------------
  // Storage. A write coinciding with reset is dropped so the memory reflects
  // only transfers that the loader actually counted.
  // ---------------------------------------------------------------------------
  imem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (xfer && !reset),
    .waddr_i (count_q[ADDR_W-1:0]),
    .wdata_i (in_byte),
    .raddr_i (fetch_addr[ADDR_W-1:0]),
    .rdata_o (fetch_data)
  );

  assign fetch_misaligned = (fetch_addr[1:0] != 2'b00);

  // Upper address bits are ignored by design
  assign w_unused_addr = ^fetch_addr[31:ADDR_W];

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int MEM_BYTES = 64;
  localparam int ADDR_W    = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [ADDR_W:0] length;
  logic            in_valid;
  logic [7:0]      in_byte;
  logic            in_ready;
  logic [31:0]     fetch_addr;
  logic [31:0]     fetch_data;
  logic            fetch_misaligned;
  logic            cpu_hold;
  logic            done;
  logic            error;
  logic [ADDR_W:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;

  imem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .length           (length),
    .in_valid         (in_valid),
    .in_byte          (in_byte),
    .in_ready         (in_ready),
    .fetch_addr       (fetch_addr),
    .fetch_data       (fetch_data),
    .fetch_misaligned (fetch_misaligned),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .error            (error),
    .byte_count       (byte_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after posedge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    length = (ADDR_W+1)'(len);
    tick();
    start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    check("in_ready_during_load", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    fetch_addr = addr;
    #1;
    check(tag, fetch_data, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"},     {31'd0, done},     32'd0);
  endtask

  logic [7:0] prog8 [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
  logic [7:0] prog4 [4] = '{8'h08, 8'h00, 8'h00, 8'h20};
  int         bad_len [3] = '{6, 0, 68};

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    length     = '0;
    in_valid   = 1'b0;
    in_byte    = '0;
    fetch_addr = '0;

    // ---------------- reset state ----------------
    do_reset();
    check_idle("reset");
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_count", {25'd0, byte_count}, 32'd0);

    // ---------------- basic 8-byte load, in_valid held high ----------------
    do_start(8);
    for (int i = 0; i < 8; i++) begin
      check("done_low_while_loading", {31'd0, done}, 32'd0);
      send_byte(prog8[i]);
    end
    check("load8_ready_dropped", {31'd0, in_ready}, 32'd0);
    check("load8_done",          {31'd0, done},     32'd1);
    check("load8_hold",          {31'd0, cpu_hold}, 32'd0);
    check("load8_count",         {25'd0, byte_count}, 32'd8);
    fetch("load8_fetch0", 32'd0, 32'h2001_0005);
    fetch("load8_fetch4", 32'd4, 32'hAC01_0000);
    check("aligned_not_misaligned", {31'd0, fetch_misaligned}, 32'd0);
    // Extra valid byte after completion must not be taken
    in_valid = 1'b1; in_byte = 8'hEE;
    tick();
    in_valid = 1'b0;
    check("post_done_count", {25'd0, byte_count}, 32'd8);
    fetch("post_done_fetch4", 32'd4, 32'hAC01_0000);

    // ---------------- backpressure reload: valid 1,0,0,1,0,0,... ----------------
    do_start(8);
    check("bp_hold_after_start", {31'd0, cpu_hold}, 32'd1);
    begin
      int acc = 0;
      for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
        check("bp_count", {25'd0, byte_count}, acc);
        check("bp_not_done", {31'd0, done}, 32'd0);
        in_valid = ((cyc % 3) == 0);
        in_byte  = in_valid ? prog8[acc] : 8'hFF;
        tick();
        if (in_valid) acc++;
        in_valid = 1'b0;
      end
      check("bp_accepted", acc, 32'd8);
    end
    check("bp_done",  {31'd0, done},     32'd1);
    check("bp_count_final", {25'd0, byte_count}, 32'd8);
    fetch("bp_fetch0", 32'd0, 32'h2001_0005);
    fetch("bp_fetch4", 32'd4, 32'hAC01_0000);

    // ---------------- illegal lengths from IDLE ----------------
    for (int j = 0; j < 3; j++) begin
      do_reset();
      do_start(bad_len[j]);
      check("bad_error", {31'd0, error}, 32'd1);
      check_idle("bad");
      in_valid = 1'b1; in_byte = 8'h77;
      tick();
      in_valid = 1'b0;
      check("bad_still_idle_ready", {31'd0, in_ready}, 32'd0);
      check("bad_count", {25'd0, byte_count}, 32'd0);
      fetch("bad_mem_untouched", 32'd0, 32'h2001_0005);
    end

    // ---------------- reset in the middle of a length-4 load ----------------
    do_reset();
    do_start(4);
    send_byte(8'h20);
    send_byte(8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midreset");
    check("midreset_count", {25'd0, byte_count}, 32'd0);
    fetch_addr = 32'd0;
    #1;
    check("midreset_fetch_hi", {16'd0, fetch_data[31:16]}, 32'h0000_2001);

    // ---------------- reload from DONE ----------------
    do_start(8);
    for (int i = 0; i < 8; i++) send_byte(prog8[i]);
    check("reload_pre_done", {31'd0, done}, 32'd1);
    do_start(4);
    check("reload_hold_rises", {31'd0, cpu_hold}, 32'd1);
    check("reload_done_falls", {31'd0, done},     32'd0);
    for (int i = 0; i < 4; i++) send_byte(prog4[i]);
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_count", {25'd0, byte_count}, 32'd4);
    fetch("reload_fetch0", 32'd0, 32'h0800_0020);
    fetch("reload_fetch4", 32'd4, 32'hAC01_0000);

    // Illegal start from DONE: error flags, DONE and memory stay
    do_start(6);
    check("done_bad_error", {31'd0, error}, 32'd1);
    check("done_bad_done",  {31'd0, done},  32'd1);
    check("done_bad_hold",  {31'd0, cpu_hold}, 32'd0);
    fetch("done_bad_fetch0", 32'd0, 32'h0800_0020);

    // ---------------- full 64-byte load: wrap, misalignment, write/fetch ----------------
    do_start(64);
    check("full_error_cleared", {31'd0, error}, 32'd0);
    fetch_addr = 32'd0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      case (i)
        0:       b = 8'h33;
        1:       b = 8'h44;
        62:      b = 8'h11;
        63:      b = 8'h22;
        default: b = 8'(i);
      endcase
      if (i == 0) begin
        // Byte 0 being written this edge: old value until the edge
        in_byte = b; in_valid = 1'b1;
        #1;
        check("same_byte_before_edge", fetch_data, 32'h0800_0020);
        tick();
        in_valid = 1'b0;
        check("same_byte_after_edge", fetch_data, 32'h3300_0020);
      end else begin
        send_byte(b);
      end
    end
    check("full_done",  {31'd0, done},       32'd1);
    check("full_count", {25'd0, byte_count}, 32'd64);
    fetch("wrap_fetch62", 32'd62, 32'h1122_3344);
    check("wrap_misaligned", {31'd0, fetch_misaligned}, 32'd1);
    fetch("fetch0", 32'd0, 32'h3344_0203);
    fetch("fetch64_alias", 32'd64, 32'h3344_0203);
    fetch("fetch_upper_bits_ignored", 32'hFFFF_FF08, 32'h0809_0A0B);
    fetch_addr = 32'd1;
    #1;
    check("misaligned_addr1", {31'd0, fetch_misaligned}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule : tb_imem_loader
`default_nettype wire
